uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing default, frame geometry, receiver
// state encoding and the odd-parity helper used by both link directions.
package uart_pkg;

  // Clocks per serial bit at 9600 baud; the transmitter baud generator uses the same value
  localparam int DEFAULT_CLKS_PER_BIT = 40;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both stages reset
// to 1 so that reset never looks like a start bit.
// With UART_RX_MAJORITY_VOTE_EN defined, the first stage is also exported so
// the receiver can see next cycle's synchronized value one cycle early.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
`ifdef UART_RX_MAJORITY_VOTE_EN
  output logic q_next,
`endif
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw line into the two-stage chain
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer register, idle-high after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];
`ifdef UART_RX_MAJORITY_VOTE_EN
  assign q_next = sync_q[0];
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start bit, 8 data bits LSB first, odd parity, stop bit.
// Each bit is decided at mid-bit; a completed frame produces a one-cycle
// data_valid pulse with parity/framing status and a resend request on error.
// A stop bit decided low parks the FSM in BREAK until the line returns high.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit becomes the majority
// of three samples around mid-bit instead of a single mid-bit sample.
// CLKS_PER_BIT must be even and at least 8.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 resend_req,
  output logic                 busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_bit_q, parity_bit_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 frame_error_q, frame_error_d;
  logic                 resend_req_q, resend_req_d;

  logic mid_bit;
  logic end_bit;
  logic bit_value;
  logic parity_bad;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_next;
  logic rx_prev_q, rx_prev_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (rx),
    .q_next (rx_next),
    .q      (rx_s)
  );

  // Vote over rx_s at HALF_BIT-1 (rx_prev_q), HALF_BIT (rx_s) and HALF_BIT+1,
  // which is already sitting in the first synchronizer stage; the decision
  // cycle therefore stays the same as in the single-sample build
  always_comb begin
    rx_prev_d = rx_s;
    bit_value = (rx_prev_q & rx_s) | (rx_prev_q & rx_next) | (rx_s & rx_next);
  end
`else
  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Single mid-bit sample decides the bit
  always_comb begin
    bit_value = rx_s;
  end
`endif

  assign mid_bit    = (cnt_q == CNT_W'(HALF_BIT));
  assign end_bit    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign parity_bad = (parity_bit_q != odd_parity(shift_q));

  // Frame FSM: bit-period counter, data/parity capture and result publication
  always_comb begin
    state_d        = state_q;
    cnt_d          = end_bit ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    parity_bit_d   = parity_bit_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    resend_req_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (mid_bit && bit_value) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (end_bit) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (mid_bit) begin
          shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
        end
        if (end_bit) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        if (mid_bit) begin
          parity_bit_d = bit_value;
        end
        if (end_bit) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (mid_bit) begin
          data_out_d     = shift_q;
          data_valid_d   = 1'b1;
          parity_error_d = parity_bad;
          frame_error_d  = ~bit_value;
          resend_req_d   = parity_bad | ~bit_value;
          cnt_d          = '0;
          state_d        = bit_value ? ST_IDLE : ST_BREAK;
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      parity_bit_q   <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      resend_req_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      parity_bit_q   <= parity_bit_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      resend_req_q   <= resend_req_d;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // One-cycle history of rx_s for the earliest vote sample
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_prev_d;
    end
  end
`endif

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign resend_req   = resend_req_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of whole frames plus hand-written
// sequences for false start, back-to-back frames, mid-frame reset and a
// mid-bit glitch whose expected outcome depends on UART_RX_MAJORITY_VOTE_EN.
module tb_uart_receiver;

  localparam int CPB  = 40;
  localparam int HALF = CPB / 2;
  // Cycles from driving the start bit until data_valid is seen: 2 synchronizer
  // cycles, then completion at 10*CPB + HALF + 2 after rx_s falls
  localparam int VALID_LATENCY = 2 + 10 * CPB + HALF + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       resend_req;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         valid_cnt     = 0;
  int         valid_cyc     = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] got_data      = 8'h00;
  logic [7:0] prev_data     = 8'h00;
  logic       got_perr      = 1'b0;
  logic       got_ferr      = 1'b0;
  logic       got_resend    = 1'b0;
  int         resend_cnt    = 0;
  int         stray_resend  = 0;
  int         frame_start   = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_bit;
    int         hold_low;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_resend;
  } vec_t;

  vec_t vecs[5];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .resend_req   (resend_req),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed frame and any resend pulse on the falling edge
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt      = valid_cnt + 1;
      prev_valid_cyc = valid_cyc;
      valid_cyc      = cyc;
      prev_data      = got_data;
      got_data       = data_out;
      got_perr       = parity_error;
      got_ferr       = frame_error;
      got_resend     = resend_req;
    end
    if (resend_req) begin
      resend_cnt = resend_cnt + 1;
      if (!data_valid) stray_resend = stray_resend + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one serial frame; called 1 time unit after a rising edge.
  // glitch_bit inverts one cycle of that line bit so rx_s flips at mid-bit;
  // abort_after > 0 stops driving after that many clock edges.
  task automatic applyStimulus(input logic [7:0] data, input logic par_flip,
                               input logic stop_bit, input int glitch_bit,
                               input int abort_after);
    logic [10:0] line;
    int edges;
    line = {stop_bit, (~^data) ^ par_flip, data, 1'b0};
    frame_start = cyc;
    edges = 0;
    for (int k = 0; k < 11; k++) begin
      for (int e = 0; e < CPB; e++) begin
        rx = line[k] ^ ((k == glitch_bit) && (e == HALF + 1));
        @(posedge clk); #1;
        edges++;
        if (abort_after > 0 && edges == abort_after) return;
      end
    end
  endtask

  initial begin
    int n0;
    int r0;
    int s1;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0,   8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1'b1, 0,   8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 0,   8'h01, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 0,   8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 200, 8'h3C, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_data_out",     32'(data_out),     32'h00);
    checkOutput("reset_data_valid",   32'(data_valid),   32'h0);
    checkOutput("reset_parity_error", 32'(parity_error), 32'h0);
    checkOutput("reset_frame_error",  32'(frame_error),  32'h0);
    checkOutput("reset_resend_req",   32'(resend_req),   32'h0);
    checkOutput("reset_busy",         32'(busy),         32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Whole frames from the table
    for (int i = 0; i < 5; i++) begin
      n0 = valid_cnt;
      r0 = resend_cnt;
      applyStimulus(vecs[i].data, vecs[i].par_flip, vecs[i].stop_bit, -1, 0);
      if (vecs[i].hold_low > 0) begin
        repeat (vecs[i].hold_low) @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d_busy_break", i), 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
      end
      checkOutput($sformatf("vec%0d_busy_idle", i),  32'(busy), 32'h0);
      checkOutput($sformatf("vec%0d_valid_cnt", i),  32'(valid_cnt - n0), 32'h1);
      checkOutput($sformatf("vec%0d_latency", i),    32'(valid_cyc - frame_start),
                  32'(VALID_LATENCY));
      checkOutput($sformatf("vec%0d_data", i),       32'(got_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_perr", i),       32'(got_perr), 32'(vecs[i].exp_perr));
      checkOutput($sformatf("vec%0d_ferr", i),       32'(got_ferr), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_resend", i),     32'(got_resend), 32'(vecs[i].exp_resend));
      checkOutput($sformatf("vec%0d_resend_cnt", i), 32'(resend_cnt - r0),
                  32'(vecs[i].exp_resend));
      repeat (20) @(posedge clk);
      #1;
    end

    // Reset at cycle ~200 of a frame: outputs return to reset values, no valid follows
    n0 = valid_cnt;
    applyStimulus(8'h81, 1'b0, 1'b1, -1, 200);
    checkOutput("abort_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_data_out",    32'(data_out),    32'h00);
    checkOutput("abort_frame_error", 32'(frame_error), 32'h0);
    checkOutput("abort_data_valid",  32'(data_valid),  32'h0);
    checkOutput("abort_busy",        32'(busy),        32'h0);
    repeat (500) @(posedge clk);
    #1;
    checkOutput("abort_no_valid", 32'(valid_cnt - n0), 32'h0);
    applyStimulus(8'h81, 1'b0, 1'b1, -1, 0);
    checkOutput("after_abort_valid_cnt", 32'(valid_cnt - n0), 32'h1);
    checkOutput("after_abort_data",      32'(got_data), 32'h81);
    checkOutput("after_abort_perr",      32'(got_perr), 32'h0);
    checkOutput("after_abort_ferr",      32'(got_ferr), 32'h0);
    repeat (20) @(posedge clk);
    #1;

    // False start: 10-cycle low pulse is rejected at the start-bit mid-point
    n0 = valid_cnt;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("false_start_busy_c20", 32'(busy), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("false_start_busy_c22", 32'(busy), 32'h0);
    repeat (460) @(posedge clk);
    #1;
    checkOutput("false_start_no_valid", 32'(valid_cnt - n0), 32'h0);

    // Back-to-back frames with no idle gap
    n0 = valid_cnt;
    r0 = resend_cnt;
    applyStimulus(8'h55, 1'b0, 1'b1, -1, 0);
    s1 = frame_start;
    applyStimulus(8'hFF, 1'b0, 1'b1, -1, 0);
    checkOutput("b2b_valid_cnt",   32'(valid_cnt - n0), 32'h2);
    checkOutput("b2b_first_data",  32'(prev_data), 32'h55);
    checkOutput("b2b_second_data", 32'(got_data), 32'hFF);
    checkOutput("b2b_spacing",     32'(valid_cyc - prev_valid_cyc), 32'(11 * CPB));
    checkOutput("b2b_first_latency", 32'(prev_valid_cyc - s1), 32'(VALID_LATENCY));
    checkOutput("b2b_no_resend",   32'(resend_cnt - r0), 32'h0);
    checkOutput("b2b_perr",        32'(got_perr), 32'h0);
    repeat (20) @(posedge clk);
    #1;

    // One-cycle inversion at the mid-bit of data bit 3 (line bit 4)
    n0 = valid_cnt;
    applyStimulus(8'hA5, 1'b0, 1'b1, 4, 0);
    checkOutput("glitch_valid_cnt", 32'(valid_cnt - n0), 32'h1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    checkOutput("glitch_data",   32'(got_data),   32'hA5);
    checkOutput("glitch_perr",   32'(got_perr),   32'h0);
    checkOutput("glitch_resend", 32'(got_resend), 32'h0);
`else
    checkOutput("glitch_data",   32'(got_data),   32'hAD);
    checkOutput("glitch_perr",   32'(got_perr),   32'h1);
    checkOutput("glitch_resend", 32'(got_resend), 32'h1);
`endif
    checkOutput("glitch_ferr", 32'(got_ferr), 32'h0);
    repeat (20) @(posedge clk);
    #1;

    checkOutput("stray_resend", 32'(stray_resend), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
